fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch front end feeding the decode/control stage of the LEGv8 core.
//  Owns the PC; issues sequential requests to a 1-cycle-latency synchronous instruction memory.
//  Buffers returned words with their PCs in a small queue; hands them to decode over valid/ready.
//  A redirect from the branch-resolution logic (B, CBZ, B.LT) flushes all buffered and in-flight words.
// PARAMETERS
//  DEPTH     4    queue entries; power of two, >= 2
//  RESET_PC  0    64-bit PC loaded at reset
// PORTS
//  clk             in   1   sole clock; all state updates on posedge
//  reset           in   1   asynchronous, active-low; 0 = in reset
//  imem_req        out  1   read request this cycle
//  imem_addr       out  64  byte address of request; bits [1:0] always 0
//  imem_rdata      in   32  instruction word, valid the cycle after imem_req
//  out_valid       out  1   out_instr/out_pc hold a valid entry
//  out_ready       in   1   decode accepts the entry when out_valid & out_ready
//  out_instr       out  32  instruction word at queue head
//  out_pc          out  64  address of out_instr
//  redirect_valid  in   1   branch taken: discard everything, refetch from redirect_pc
//  redirect_pc     in   64  new fetch address; bits [1:0] forced to 0 internally
// BEHAVIOUR
//  - Reset (reset==0, async): pc=RESET_PC, count=0, inflight=0, rd/wr ptr=0;
//    outputs imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
//  - imem_req = ~redirect_valid & (count + inflight < DEPTH); imem_addr = pc (registered).
//    Request accepted unconditionally by memory; on issue: pc <= pc+4, inflight<=1, inflight_pc<=pc.
//  - Response: cycle after issue, if inflight & ~redirect_valid: push {imem_rdata, inflight_pc}.
//  - Credit rule guarantees no push into a full queue; no overflow handling needed.
//    An assertion flags push while count==DEPTH.
//  - Pop on out_valid & out_ready. out_valid = (count!=0), from registered state only.
//    Head fields are likewise registered; no combinational path from imem_rdata or out_ready to outputs.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH. count spans 0..DEPTH, so it is $clog2(DEPTH)+1 bits wide.
//  - Redirect priority: a cycle with redirect_valid=1 overrides every other action:
//    count<=0, ptrs<=0, inflight<=0, pending response dropped, no issue,
//    pc <= {redirect_pc[63:2],2'b00}, and any pop that cycle is void.
//  - Redirect timing: redirect in cycle N; issue at redirect_pc in N+1; push at end of N+2;
//    out_valid=1 with out_pc=redirect_pc in N+3.
//  - Back-to-back redirects: the last one wins; each restarts the N+1 issue.
//  - Steady state with out_ready=1: one instruction per cycle after the 3-cycle fill.
//  - PC arithmetic is 64-bit unsigned and wraps 0xFFFF_FFFF_FFFF_FFFC -> 0 silently.
//  - Async reset mid-operation: all state cleared immediately. The first issue comes in
//    the first clk edge after deassertion, at RESET_PC.
// STRUCTURE
//  - cpu_pkg holds INSTR_W=32, ADDR_W=64, PC_STEP=4, and typedef struct packed {
//    logic [63:0] pc; logic [31:0] instr; } fetch_entry_t. The decode side uses the same struct.
//  - Sub-module fetch_fifo (fetch_entry_t, DEPTH): push/pop/flush, count, head output, async active-low reset.
//  - fetch_stage holds the PC register, the inflight flag and tag, issue/credit logic, and redirect priority.
// TESTING
//  1 Reset release, out_ready=1, imem returns addr-tagged words:
//    out_pc = 0,4,8,... one per cycle from cycle 3; instr matches.
//  2 out_ready=0 for 10 cycles: exactly DEPTH=4 entries queued, imem_req=0 once credits are exhausted.
//    Release: pcs 0,4,8,12,16 emerge in order, no gaps or duplicates.
//  3 Redirect to 0x1000 while queue holds 3 entries and one is in flight:
//    none delivered after redirect; next out_pc=0x1000 exactly 3 cycles later.
//  4 redirect_pc=0x2003 -> fetch at 0x2000; redirects on two consecutive cycles (0x40, 0x80)
//    -> first delivered pc 0x80.
//  5 Assert reset low mid-stream (async, between edges): out_valid and imem_req drop immediately.
//    After release, refetch starts at RESET_PC.
//  6 Random out_ready/redirect for 10k cycles against a reference PC model:
//    delivered sequence matches, FIFO never overflows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Holds the instruction/address widths, the sequential PC increment, and the
// fetch_entry_t record that fetch hands to decode (pc + instruction word).
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched instructions.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write push_data at the tail
//   pop         drop the head entry (ignored when empty)
//   flush       discard every entry; wins over push and pop
//   push_data   entry to write
//   head        entry at the head (registered storage, no input bypass)
//   count       number of valid entries, 0..DEPTH
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The fetch credit check must make this unreachable.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (count_q == FULL))
    );

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end.
// Owns the PC, issues one sequential read per cycle to a 1-cycle-latency
// instruction memory while queue credits remain, buffers returned words with
// their PCs and hands them to decode over valid/ready. A redirect flushes all
// buffered and in-flight words and restarts fetch at the new PC.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_req, imem_addr         read request and word-aligned byte address
//   imem_rdata                  read data, valid the cycle after imem_req
//   out_valid, out_ready        handshake toward decode
//   out_instr, out_pc           head entry (registered)
//   redirect_valid, redirect_pc taken-branch restart request and target
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    outstanding;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Every word in the queue or in flight holds a credit; issue only while
    // one is free so a response always has a slot.
    assign outstanding = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    // Gating with reset drops the request as soon as reset asserts.
    assign issue       = reset & ~redirect_valid & (outstanding < DEPTH_C);

    assign push       = inflight_q & ~redirect_valid;
    assign pop        = out_valid & out_ready & ~redirect_valid;
    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory contents.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    // 1-cycle-latency synchronous memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_at(imem_addr);
    end

    int checks = 0;
    int errors = 0;
    int obs_req_cnt = 0;

    // Reference: words issued but not yet delivered, in fetch order.
    logic [63:0] m_fetch_pc;
    logic [63:0] m_queue[$];
    logic        m_inflight;
    logic [63:0] m_inflight_pc;
    logic [63:0] delivered[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_queue.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = RESET_PC;
    endtask

    // One cycle: starts just after a negedge, ends on the next negedge.
    task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc,
                        output logic took);
        logic        exp_req;
        logic [63:0] hd;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        exp_req = !rv && ((m_queue.size() + (m_inflight ? 1 : 0)) < int'(DEPTH));
        check_eq("imem_req", 64'(imem_req), 64'(exp_req));
        check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("out_valid", 64'(out_valid), 64'(m_queue.size() != 0));
        if (m_queue.size() != 0) begin
            hd = m_queue[0];
            check_eq("out_pc", out_pc, hd);
            check_eq("out_instr", 64'(out_instr), 64'(word_at(hd)));
        end
        if (imem_req) obs_req_cnt++;
        took = out_valid && rdy && !rv;
        if (took) delivered.push_back(out_pc);
        @(posedge clk);
        if (rv) begin
            m_queue.delete();
            m_inflight = 1'b0;
            m_fetch_pc = {rpc[63:2], 2'b00};
        end else begin
            if (rdy && m_queue.size() != 0) void'(m_queue.pop_front());
            if (m_inflight) m_queue.push_back(m_inflight_pc);
            if (exp_req) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_fetch_pc;
                m_fetch_pc    = m_fetch_pc + 64'd4;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // n cycles with out_ready=1 and no redirect; reports the first cycle (0-based)
    // at which the DUT delivered an entry, and its pc.
    task automatic run_ready(input int n, output int first_k, output logic [63:0] first_pc);
        logic took;
        first_k  = -1;
        first_pc = '0;
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, 64'h0, took);
            if (took && first_k < 0) begin
                first_k  = k;
                first_pc = delivered[delivered.size() - 1];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        logic [63:0] pc;
        logic        took;
        logic        reached;
        logic        rdy, rv;
        logic [63:0] rpc;

        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        model_reset();

        // Reset state
        #12;
        check_eq("rst_imem_req", 64'(imem_req), 64'd0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_instr", 64'(out_instr), 64'd0);
        check_eq("rst_out_pc", out_pc, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: streaming from reset, one per cycle after fill
        delivered.delete();
        run_ready(12, k, pc);
        check_eq("t1_first_cycle", 64'(k), 64'd2);
        check_eq("t1_first_pc", pc, RESET_PC);
        check_eq("t1_throughput", 64'(delivered.size()), 64'd10);

        // 2: stall fills exactly DEPTH entries, then drains in order
        step(1'b0, 1'b1, 64'h0, took);
        obs_req_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0, took);
        check_eq("t2_issued", 64'(obs_req_cnt), 64'(DEPTH));
        delivered.delete();
        run_ready(8, k, pc);
        check_eq("t2_first_cycle", 64'(k), 64'd0);
        check_eq("t2_count", 64'(delivered.size() >= 5), 64'd1);
        if (delivered.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check_eq($sformatf("t2_pc%0d", i), delivered[i], 64'(4 * i));
            end
        end

        // 3: redirect with 3 queued + 1 in flight
        step(1'b0, 1'b1, 64'h0, took);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (m_queue.size() == 3 && m_inflight) reached = 1'b1;
            else step(1'b0, 1'b0, 64'h0, took);
        end
        check_eq("t3_setup", 64'(reached), 64'd1);
        delivered.delete();
        step(1'b1, 1'b1, 64'h1000, took);
        check_eq("t3_void_pop", 64'(took), 64'd0);
        run_ready(6, k, pc);
        check_eq("t3_latency", 64'(k), 64'd2);
        check_eq("t3_pc", pc, 64'h1000);

        // 4: unaligned target, then back-to-back redirects
        step(1'b1, 1'b1, 64'h2003, took);
        run_ready(6, k, pc);
        check_eq("t4_align_pc", pc, 64'h2000);
        step(1'b1, 1'b1, 64'h40, took);
        step(1'b1, 1'b1, 64'h80, took);
        run_ready(6, k, pc);
        check_eq("t4_b2b_latency", 64'(k), 64'd2);
        check_eq("t4_b2b_pc", pc, 64'h80);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, took);
        delivered.delete();
        run_ready(8, k, pc);
        check_eq("wrap_count", 64'(delivered.size() >= 4), 64'd1);
        if (delivered.size() >= 4) begin
            check_eq("wrap_pc0", delivered[0], 64'hFFFF_FFFF_FFFF_FFF8);
            check_eq("wrap_pc1", delivered[1], 64'hFFFF_FFFF_FFFF_FFFC);
            check_eq("wrap_pc2", delivered[2], 64'h0);
            check_eq("wrap_pc3", delivered[3], 64'h4);
        end

        // 5: asynchronous reset between edges
        run_ready(4, k, pc);
        out_ready = 1'b1;
        #2;
        check_eq("t5_pre_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("t5_valid_drop", 64'(out_valid), 64'd0);
        check_eq("t5_req_drop", 64'(imem_req), 64'd0);
        check_eq("t5_addr", imem_addr, RESET_PC);
        check_eq("t5_out_pc", out_pc, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_ready(6, k, pc);
        check_eq("t5_restart_latency", 64'(k), 64'd2);
        check_eq("t5_restart_pc", pc, RESET_PC);

        // 6: random ready/redirect against the reference
        for (int i = 0; i < 10000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 24) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) rpc[63:20] = '0;
            step(rdy, rv, rpc, took);
        end
        step(1'b1, 1'b1, 64'h3000, took);
        run_ready(6, k, pc);
        check_eq("t6_final_latency", 64'(k), 64'd2);
        check_eq("t6_final_pc", pc, 64'h3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
